// File: rtl/udp_tx_arbiter.sv
// Two-channel whole-packet arbiter in front of the UDP TX encapsulation (64-bit AXIS).
// Round-robin by default; define UDP_ARB_STRICT_PRIO_EN to make c0 always win contention.
module udp_tx_arbiter #(
    parameter int P_IFG_CYCLES = 2,
    parameter int P_TIMEOUT    = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] s_axis_c0_data,
    input  logic [31:0] s_axis_c0_user,
    input  logic [7:0]  s_axis_c0_keep,
    input  logic        s_axis_c0_last,
    input  logic        s_axis_c0_valid,
    output logic        s_axis_c0_ready,
    input  logic [63:0] s_axis_c1_data,
    input  logic [31:0] s_axis_c1_user,
    input  logic [7:0]  s_axis_c1_keep,
    input  logic        s_axis_c1_last,
    input  logic        s_axis_c1_valid,
    output logic        s_axis_c1_ready,
    output logic [63:0] m_axis_udp_data,
    output logic [31:0] m_axis_udp_user,
    output logic [7:0]  m_axis_udp_keep,
    output logic        m_axis_udp_last,
    output logic        m_axis_udp_valid,
    input  logic        m_axis_udp_ready,
    output logic [1:0]  o_grant,
    output logic        o_timeout,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // The IDLE arbitration cycle is the final gap cycle, so GAP itself lasts one cycle less.
    localparam int          GAP_LEN  = (P_IFG_CYCLES > 1) ? P_IFG_CYCLES - 1 : 0;
    localparam logic [15:0] GAP_LAST = 16'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [15:0] WD_LIMIT = 16'(P_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        ptr, ptr_nxt;
    logic [31:0] user_q, user_nxt;
    logic [15:0] wd_cnt, wd_nxt;
    logic [15:0] gap_cnt, gap_nxt;
    logic        pick;

    logic [63:0] own_data;
    logic [7:0]  own_keep;
    logic        own_last;
    logic        own_valid;
    logic        beat_acc;

    assign own_data  = owner ? s_axis_c1_data  : s_axis_c0_data;
    assign own_keep  = owner ? s_axis_c1_keep  : s_axis_c0_keep;
    assign own_last  = owner ? s_axis_c1_last  : s_axis_c0_last;
    assign own_valid = owner ? s_axis_c1_valid : s_axis_c0_valid;

    // A beat moves on any cycle where valid and ready are both high; the source holds the
    // beat stable until then. Only the owner sees ready, and only while in XFER.
    assign beat_acc = (state == ST_XFER) && own_valid && m_axis_udp_ready;

`ifdef UDP_ARB_STRICT_PRIO_EN
    assign pick = s_axis_c0_valid ? 1'b0 : 1'b1;
`else
    assign pick = (s_axis_c0_valid && s_axis_c1_valid) ? ptr : s_axis_c1_valid;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            owner   <= 1'b0;
            ptr     <= 1'b0;
            user_q  <= 32'd0;
            wd_cnt  <= 16'd0;
            gap_cnt <= 16'd0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            user_q  <= user_nxt;
            wd_cnt  <= wd_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        ptr_nxt          = ptr;
        user_nxt         = user_q;
        wd_nxt           = wd_cnt;
        gap_nxt          = gap_cnt;
        m_axis_udp_data  = 64'd0;
        m_axis_udp_keep  = 8'd0;
        m_axis_udp_last  = 1'b0;
        m_axis_udp_valid = 1'b0;
        s_axis_c0_ready  = 1'b0;
        s_axis_c1_ready  = 1'b0;
        o_timeout        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (s_axis_c0_valid || s_axis_c1_valid) begin
                    owner_nxt = pick;
                    user_nxt  = pick ? s_axis_c1_user : s_axis_c0_user;
                    wd_nxt    = 16'd0;
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                m_axis_udp_data  = own_data;
                m_axis_udp_keep  = own_keep;
                m_axis_udp_last  = own_last;
                m_axis_udp_valid = own_valid;
                s_axis_c0_ready  = !owner && m_axis_udp_ready;
                s_axis_c1_ready  = owner && m_axis_udp_ready;
                if (beat_acc) begin
                    wd_nxt = 16'd0;
                    if (own_last) begin
                        ptr_nxt   = !owner;
                        gap_nxt   = 16'd0;
                        state_nxt = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;
                    end
                end else if (!own_valid) begin
                    // Only a silent owner ages the watchdog; downstream back-pressure does not.
                    if (wd_cnt == WD_LIMIT) begin
                        o_timeout = 1'b1;
                        ptr_nxt   = !owner;
                        gap_nxt   = 16'd0;
                        state_nxt = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        wd_nxt = wd_cnt + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 16'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign m_axis_udp_user = user_q;
    assign o_grant         = (state != ST_XFER) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign o_dbg_state     = state;

endmodule
